// File: rtl/wb_sdram_pkg.sv
// wb_sdram_pkg: shared constants, arbiter state and helpers for the SDRAM Wishbone front end.
package wb_sdram_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin / fixed-priority picker returning one-hot winner and index.
module wb_rr_pick
   import wb_sdram_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int FIXEDPRI = 0,
   parameter int IW       = clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [IW-1:0]       ptr,
   output logic [CHANNELS-1:0] win,
   output logic [IW-1:0]       idx
);

   // Scan from the farthest offset back to the nearest so the closest requester overwrites.
   always_comb begin
      int c;
      c   = 0;
      win = '0;
      idx = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         c = FIXEDPRI != 0 ? k : (int'(ptr) + k) % CHANNELS;
         if (req[c]) begin
            win    = '0;
            win[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/wb_sdram_arb.sv
// wb_sdram_arb: N-channel Wishbone burst arbiter in front of wb_sdram_ctrl,
// with round-robin or fixed grant and a per-tenure beat cap.
module wb_sdram_arb
   import wb_sdram_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int ADDRESS  = 23,
   parameter int WIDTH    = 32,
   parameter int MAXBURST = 16,
   parameter int FIXEDPRI = 0,
   localparam int SELW    = WIDTH / 8
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic [CHANNELS-1:0]         m_cyc_i,
   input  logic [CHANNELS-1:0]         m_stb_i,
   input  logic [CHANNELS-1:0]         m_we_i,
   input  logic [3*CHANNELS-1:0]       m_cti_i,
   input  logic [2*CHANNELS-1:0]       m_bte_i,
   input  logic [ADDRESS*CHANNELS-1:0] m_adr_i,
   input  logic [SELW*CHANNELS-1:0]    m_sel_i,
   input  logic [WIDTH*CHANNELS-1:0]   m_dat_i,
   output logic [CHANNELS-1:0]         m_ack_o,
   output logic [CHANNELS-1:0]         m_rty_o,
   output logic [CHANNELS-1:0]         m_err_o,
   output logic [WIDTH-1:0]            m_dat_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic                        s_we_o,
   output logic [2:0]                  s_cti_o,
   output logic [1:0]                  s_bte_o,
   output logic [ADDRESS-1:0]          s_adr_o,
   output logic [SELW-1:0]             s_sel_o,
   output logic [WIDTH-1:0]            s_dat_o,
   input  logic                        s_ack_i,
   input  logic                        s_rty_i,
   input  logic                        s_err_i,
   input  logic [WIDTH-1:0]            s_dat_i
);

   localparam int IW = clog2(CHANNELS);
   localparam int CW = MAXBURST > 0 ? clog2(MAXBURST + 1) : 1;

   arb_state_t          state, state_d;
   logic [IW-1:0]       grant, grant_d, ptr, ptr_d, pick_idx;
   logic [CW-1:0]       cnt, cnt_d;
   logic [CHANNELS-1:0] req, pick_win;
   logic [2:0]          g_cti;
   logic                busy, eob, done;

   assign req   = m_cyc_i & m_stb_i;
   assign busy  = state == ST_BUSY;
   assign g_cti = m_cti_i[grant*3 +: 3];

   wb_rr_pick #(.CHANNELS(CHANNELS), .FIXEDPRI(FIXEDPRI), .IW(IW)) u_pick (
      .req (req),
      .ptr (ptr),
      .win (pick_win),
      .idx (pick_idx)
   );

   // Cap reached on an incrementing burst: terminate it here, the master re-arbitrates later.
   assign eob = busy && MAXBURST != 0 && cnt == CW'(MAXBURST - 1) && g_cti == CTI_INCR;

   assign s_cyc_o = busy & m_cyc_i[grant];
   assign s_stb_o = busy & m_stb_i[grant];
   assign s_we_o  = busy & m_we_i[grant];
   assign s_cti_o = !busy ? CTI_CLASSIC : eob ? CTI_EOB : g_cti;
   assign s_bte_o = busy ? m_bte_i[grant*2 +: 2] : '0;
   assign s_adr_o = busy ? m_adr_i[grant*ADDRESS +: ADDRESS] : '0;
   assign s_sel_o = busy ? m_sel_i[grant*SELW +: SELW] : '0;
   assign s_dat_o = busy ? m_dat_i[grant*WIDTH +: WIDTH] : '0;

   assign m_ack_o = {{(CHANNELS-1){1'b0}}, busy & s_ack_i} << grant;
   assign m_rty_o = {{(CHANNELS-1){1'b0}}, busy & s_rty_i} << grant;
   assign m_err_o = {{(CHANNELS-1){1'b0}}, busy & s_err_i} << grant;
   assign m_dat_o = s_dat_i;

   assign done = !m_cyc_i[grant] || (s_ack_i && s_cti_o == CTI_EOB) || s_rty_i || s_err_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= ST_IDLE;
         grant <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         grant <= grant_d;
         ptr   <= ptr_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      grant_d = grant;
      ptr_d   = ptr;
      cnt_d   = cnt;
      if (!busy) begin
         if (|pick_win) begin
            state_d = ST_BUSY;
            grant_d = pick_idx;
            cnt_d   = '0;
         end
      end else begin
         if (s_ack_i) cnt_d = cnt + 1'b1;
         if (done) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = grant == IW'(CHANNELS - 1) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_sdram_arb.sv
// tb_wb_sdram_arb: directed bench; a round-robin and a fixed-priority arbiter,
// each with its own simple master models and a zero-wait-state slave.
module tb_wb_sdram_arb;

   localparam int CH = 4;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam logic [DW-1:0] SDAT = 32'hA5A5_5A5A;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [CH-1:0]    cyc[2], stb[2], we[2];
   logic [3*CH-1:0]  cti[2];
   logic [2*CH-1:0]  bte[2];
   logic [AW*CH-1:0] adr_f[2];
   logic [4*CH-1:0]  sel[2];
   logic [DW*CH-1:0] dat[2];
   logic [CH-1:0]    ack[2], rty[2], err[2];
   logic [DW-1:0]    mdat[2], s_dato[2];
   logic             s_cyc[2], s_stb[2], s_we[2];
   logic [2:0]       s_cti[2];
   logic [1:0]       s_bte[2];
   logic [AW-1:0]    s_adr[2];
   logic [3:0]       s_sel[2];
   logic             s_ack[2], s_rty[2];
   logic             slv_rty;
   logic [DW-1:0]    sdat = SDAT;

   assign s_ack[0] = s_cyc[0] & s_stb[0] & ~slv_rty;
   assign s_rty[0] = s_cyc[0] & s_stb[0] & slv_rty;
   assign s_ack[1] = s_cyc[1] & s_stb[1];
   assign s_rty[1] = 1'b0;

   wb_sdram_arb #(.CHANNELS(CH), .ADDRESS(AW), .WIDTH(DW), .MAXBURST(16), .FIXEDPRI(0)) u_rr (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m_cyc_i(cyc[0]), .m_stb_i(stb[0]), .m_we_i(we[0]), .m_cti_i(cti[0]), .m_bte_i(bte[0]),
      .m_adr_i(adr_f[0]), .m_sel_i(sel[0]), .m_dat_i(dat[0]),
      .m_ack_o(ack[0]), .m_rty_o(rty[0]), .m_err_o(err[0]), .m_dat_o(mdat[0]),
      .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]), .s_cti_o(s_cti[0]), .s_bte_o(s_bte[0]),
      .s_adr_o(s_adr[0]), .s_sel_o(s_sel[0]), .s_dat_o(s_dato[0]),
      .s_ack_i(s_ack[0]), .s_rty_i(s_rty[0]), .s_err_i(1'b0), .s_dat_i(sdat)
   );

   wb_sdram_arb #(.CHANNELS(CH), .ADDRESS(AW), .WIDTH(DW), .MAXBURST(16), .FIXEDPRI(1)) u_fix (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m_cyc_i(cyc[1]), .m_stb_i(stb[1]), .m_we_i(we[1]), .m_cti_i(cti[1]), .m_bte_i(bte[1]),
      .m_adr_i(adr_f[1]), .m_sel_i(sel[1]), .m_dat_i(dat[1]),
      .m_ack_o(ack[1]), .m_rty_o(rty[1]), .m_err_o(err[1]), .m_dat_o(mdat[1]),
      .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]), .s_cti_o(s_cti[1]), .s_bte_o(s_bte[1]),
      .s_adr_o(s_adr[1]), .s_sel_o(s_sel[1]), .s_dat_o(s_dato[1]),
      .s_ack_i(s_ack[1]), .s_rty_i(s_rty[1]), .s_err_i(1'b0), .s_dat_i(sdat)
   );

   int            n_tests = 0;
   int            n_fail = 0;
   int            left[2][CH];
   logic [AW-1:0] madr[2][CH];
   bit            incr[2][CH];
   bit            gap[2][CH];
   logic [CH-1:0] cap[2];
   int            ord0[$];
   int            ord1[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int oh2i(input logic [CH-1:0] v);
      for (int i = 0; i < CH; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < CH; i++) begin
            bit act;
            act = left[d][i] > 0 && !gap[d][i];
            cyc[d][i] = act;
            stb[d][i] = act;
            we[d][i]  = incr[d][i];
            cti[d][i*3 +: 3] = !act ? 3'b000 : left[d][i] == 1 ? 3'b111 : incr[d][i] ? 3'b010 : 3'b000;
            bte[d][i*2 +: 2] = 2'b00;
            sel[d][i*4 +: 4] = 4'hF;
            adr_f[d][i*AW +: AW] = madr[d][i];
            dat[d][i*DW +: DW] = {8'(i), 1'b0, madr[d][i]};
         end
      end
   endtask

   // Masters advance on the ack seen before the edge; classic masters drop cyc for one cycle after each ack.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < CH; i++) begin
            if (cap[d][i]) begin
               madr[d][i]++;
               left[d][i]--;
               gap[d][i] = !incr[d][i];
            end else gap[d][i] = 1'b0;
         end
      end
      drive();
      @(negedge clk);
      cap[0] = ack[0];
      cap[1] = ack[1];
      if (ack[0] != 0) ord0.push_back(oh2i(ack[0]));
      if (ack[1] != 0) ord1.push_back(oh2i(ack[1]));
      check("ack_onehot", 32'($onehot0(ack[0])), 32'd1);
   endtask

   task automatic setup(input int i, input logic [AW-1:0] base, input int n, input bit inc);
      for (int d = 0; d < 2; d++) begin
         left[d][i] = n;
         madr[d][i] = base;
         incr[d][i] = inc;
         gap[d][i]  = 1'b0;
      end
      drive();
   endtask

   task automatic clear_all();
      for (int d = 0; d < 2; d++) begin
         cap[d] = '0;
         for (int i = 0; i < CH; i++) begin
            left[d][i] = 0;
            madr[d][i] = '0;
            incr[d][i] = 1'b0;
            gap[d][i]  = 1'b0;
         end
      end
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      slv_rty = 1'b0;
      clear_all();
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [CH-1:0] e;
      slv_rty = 1'b0;
      clear_all();
      // reset with every channel requesting, then round-robin / fixed order of single classic reads
      rst_n = 1'b0;
      for (int i = 0; i < CH; i++) setup(i, AW'(i * 'h100), 1000, 1'b0);
      cycle();
      cycle();
      check("rst_scyc", 32'(s_cyc[0]), 0);
      check("rst_ack", 32'(ack[0]), 0);
      check("rst_sadr", 32'(s_adr[0]), 0);
      check("rst_mdat", mdat[0], SDAT);
      ord0.delete();
      ord1.delete();
      rst_n = 1'b1;
      cycle();
      check("rel_scyc", 32'(s_cyc[0]), 1);
      check("rel_grant", 32'(ack[0]), 32'b0001);
      n = 0;
      while (ord0.size() < 5 && n < 60) begin
         cycle();
         n++;
      end
      check("rr_count", ord0.size() >= 5, 1);
      check("rr_0", ord0.size() > 0 ? ord0[0] : -1, 0);
      check("rr_1", ord0.size() > 1 ? ord0[1] : -1, 1);
      check("rr_2", ord0.size() > 2 ? ord0[2] : -1, 2);
      check("rr_3", ord0.size() > 3 ? ord0[3] : -1, 3);
      check("rr_4", ord0.size() > 4 ? ord0[4] : -1, 0);
      check("fix_count", ord1.size() >= 3, 1);
      check("fix_0", ord1.size() > 0 ? ord1[0] : -1, 0);
      check("fix_1", ord1.size() > 1 ? ord1[1] : -1, 0);
      check("fix_2", ord1.size() > 2 ? ord1[2] : -1, 0);

      // two 16-beat incrementing writes, ch1 then ch2 after one idle cycle
      do_reset();
      setup(1, 23'h100, 16, 1'b1);
      setup(2, 23'h200, 16, 1'b1);
      for (int c = 0; c < 34; c++) begin
         cycle();
         e = c < 16 ? 4'b0010 : (c >= 17 && c < 33) ? 4'b0100 : 4'b0000;
         check("burst_ack", 32'(ack[0]), 32'(e));
         if (c == 0) check("burst_adr1", 32'(s_adr[0]), 32'h100);
         if (c == 0) check("burst_dat1", s_dato[0], {8'd1, 1'b0, 23'h100});
         if (c == 0) check("burst_we", 32'(s_we[0]), 1);
         if (c == 15) check("burst_last_cti", 32'(s_cti[0]), 32'b111);
         if (c == 16) check("burst_gap", 32'(s_cyc[0]), 0);
         if (c == 17) check("burst_adr2", 32'(s_adr[0]), 32'h200);
      end

      // 32-beat burst cut at beat 16, waiting ch3 served, then ch0 resumes at 16
      do_reset();
      setup(0, 23'h0, 32, 1'b1);
      setup(3, 23'h300, 1, 1'b1);
      for (int c = 0; c < 20; c++) begin
         cycle();
         e = c < 16 ? 4'b0001 : c == 17 ? 4'b1000 : c == 19 ? 4'b0001 : 4'b0000;
         check("cap_ack", 32'(ack[0]), 32'(e));
         if (c == 14) check("cap_cti14", 32'(s_cti[0]), 32'b010);
         if (c == 15) check("cap_cti_eob", 32'(s_cti[0]), 32'b111);
         if (c == 16) check("cap_gap", 32'(s_cyc[0]), 0);
         if (c == 17) check("cap_ch3_adr", 32'(s_adr[0]), 32'h300);
         if (c == 19) check("cap_resume_adr", 32'(s_adr[0]), 16);
         if (c == 19) check("cap_resume_cti", 32'(s_cti[0]), 32'b010);
      end

      // retry routed to the granted channel only, pointer advances past it
      do_reset();
      setup(2, 23'h220, 1, 1'b1);
      setup(3, 23'h330, 1, 1'b1);
      slv_rty = 1'b1;
      cycle();
      check("rty_route", 32'(rty[0]), 32'b0100);
      check("rty_noack", 32'(ack[0]), 0);
      check("rty_adr", 32'(s_adr[0]), 32'h220);
      cycle();
      check("rty_idle", 32'(s_cyc[0]), 0);
      check("rty_clear", 32'(rty[0]), 0);
      slv_rty = 1'b0;
      cycle();
      check("rty_next", 32'(ack[0]), 32'b1000);

      // reset asserted on beat 5 of a burst
      do_reset();
      setup(1, 23'h100, 16, 1'b1);
      for (int c = 0; c < 5; c++) cycle();
      check("mid_beat5", 32'(ack[0]), 32'b0010);
      check("mid_adr5", 32'(s_adr[0]), 32'h104);
      rst_n = 1'b0;
      cap[0] = '0;
      cap[1] = '0;
      #1;
      check("mid_scyc", 32'(s_cyc[0]), 0);
      check("mid_sstb", 32'(s_stb[0]), 0);
      check("mid_sadr", 32'(s_adr[0]), 0);
      check("mid_scti", 32'(s_cti[0]), 0);
      check("mid_ack", 32'(ack[0]), 0);
      cycle();
      setup(0, 23'h0, 1, 1'b1);
      rst_n = 1'b1;
      cycle();
      check("mid_ptr0", 32'(ack[0]), 32'b0001);
      cycle();
      check("mid_gap", 32'(s_cyc[0]), 0);
      cycle();
      check("mid_resume", 32'(ack[0]), 32'b0010);
      check("mid_resume_adr", 32'(s_adr[0]), 32'h104);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
